multicycle_addsub: RTL and testbench

- Parametrised, multi-cycle successor to the single-cycle 32-bit add/subtract-and-compare datapath.
- Processes CHUNK bits per cycle through one shared chunk adder, carrying between chunks.
- Produces sum/difference, signed overflow, not-equal and signed less-than.
- Valid/ready handshakes on both sides; sits between the issue stage and writeback where area matters more than latency.

---
 rtl/addsub_pkg.sv | 18 +
 rtl/multicycle_addsub_chunk_adder.sv | 23 ++
 rtl/multicycle_addsub.sv | 131 +++++++++++++
 tb/tb_multicycle_addsub.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared types and helpers for the multi-cycle add/subtract-and-compare datapath.
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam logic ADD = 1'b0;
    localparam logic SUB = 1'b1;

    // Chunk counter width; never zero, even when a single chunk covers the word.
    function automatic int unsigned cnt_width(input int unsigned nchunk);
        return (nchunk <= 1) ? 1 : $clog2(nchunk);
    endfunction

endpackage

// File: rtl/multicycle_addsub_chunk_adder.sv
// CHUNK-bit adder slice; c_msb (carry into the top bit) feeds signed-overflow detection.
module chunk_adder #(
    parameter int unsigned CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co,
    output logic             c_msb
);

    logic [CHUNK:0] full;

    always_comb begin
        full  = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, ci};
        s     = full[CHUNK-1:0];
        co    = full[CHUNK];
        // s = a ^ b ^ c at every bit, so the carry into the MSB falls out directly.
        c_msb = s[CHUNK-1] ^ a[CHUNK-1] ^ b[CHUNK-1];
    end

endmodule

// File: rtl/multicycle_addsub.sv
// Multi-cycle add/subtract-and-compare, CHUNK bits per cycle with valid/ready on both sides.
// Optional result clamping on signed overflow: define ADDSUB_SATURATE_EN.
module multicycle_addsub
    import addsub_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_A,
    input  logic [WIDTH-1:0] data_B,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             isNotEqual,
    output logic             isLessThan
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned CW     = cnt_width(NCHUNK);
    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

    state_t          state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             nz;

    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK-1:0] s;
    logic             co;
    logic             c_msb;
    logic [WIDTH-1:0] final_sum;
    logic [WIDTH-1:0] final_result;
    logic             ovf_next;

    always_comb begin
        a_chunk = a_reg[cnt*CHUNK +: CHUNK];
        b_chunk = b_reg[cnt*CHUNK +: CHUNK];
    end

    chunk_adder #(.CHUNK(CHUNK)) u_chunk (
        .a     (a_chunk),
        .b     (b_chunk),
        .ci    (carry),
        .s     (s),
        .co    (co),
        .c_msb (c_msb)
    );

    // Full word as it will stand once the final chunk lands.
    always_comb begin
        final_sum                     = sum_reg;
        final_sum[WIDTH-1 -: CHUNK]   = s;
        ovf_next                      = c_msb ^ co;
        final_result                  = final_sum;
`ifdef ADDSUB_SATURATE_EN
        if (ovf_next) begin
            final_result = final_sum[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}}
                                              : {1'b1, {(WIDTH-1){1'b0}}};
        end
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            a_reg      <= '0;
            b_reg      <= '0;
            sum_reg    <= '0;
            carry      <= 1'b0;
            cnt        <= '0;
            nz         <= 1'b0;
            result     <= '0;
            overflow   <= 1'b0;
            isNotEqual <= 1'b0;
            isLessThan <= 1'b0;
            out_valid  <= 1'b0;
            in_ready   <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg    <= data_A;
                        b_reg    <= data_B ^ {WIDTH{cin == SUB}};
                        carry    <= cin;
                        cnt      <= '0;
                        nz       <= 1'b0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    sum_reg[cnt*CHUNK +: CHUNK] <= s;
                    carry <= co;
                    nz    <= nz | (|s);
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        result     <= final_result;
                        overflow   <= ovf_next;
                        isLessThan <= s[CHUNK-1] ^ ovf_next;
                        isNotEqual <= nz | (|s);
                        out_valid  <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_addsub.sv
// Directed, table-driven bench for multicycle_addsub at WIDTH=32, CHUNK=8.
module tb_multicycle_addsub;

`ifdef ADDSUB_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    localparam int NCH = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] data_A;
    logic [31:0] data_B;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        overflow;
    logic        isNotEqual;
    logic        isLessThan;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [31:0] res;
        logic        ovf;
        logic        ne;
        logic        lt;
    } vec_t;

    vec_t vecs[11];

    multicycle_addsub #(.WIDTH(32), .CHUNK(8)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .data_A     (data_A),
        .data_B     (data_B),
        .cin        (cin),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .overflow   (overflow),
        .isNotEqual (isNotEqual),
        .isLessThan (isLessThan)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, " in_ready"},  32'(in_ready), 32'd1);
        check({tag, " out_valid"}, 32'(out_valid), 32'd0);
    endtask

    // Present operands while idle; returns just after the accepting edge.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic c);
        @(negedge clock);
        data_A   = a;
        data_B   = b;
        cin      = c;
        in_valid = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        issue(v.a, v.b, v.cin);
        check({tag, " in_ready after accept"}, 32'(in_ready), 32'd0);
        for (int k = 1; k <= NCH; k++) begin
            @(posedge clock);
            #1;
            if (k == NCH - 1) check({tag, " early out_valid"}, 32'(out_valid), 32'd0);
        end
        check({tag, " out_valid latency"}, 32'(out_valid), 32'd1);
        check({tag, " result"},     result, v.res);
        check({tag, " overflow"},   32'(overflow), 32'(v.ovf));
        check({tag, " isNotEqual"}, 32'(isNotEqual), 32'(v.ne));
        check({tag, " isLessThan"}, 32'(isLessThan), 32'(v.lt));
        @(negedge clock);
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        check_idle({tag, " post-handshake"});
    endtask

    initial begin
        logic [31:0] held;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        data_A    = '0;
        data_B    = '0;
        cin       = 1'b0;

        vecs[0]  = '{32'h7FFFFFFF, 32'h00000001, 1'b0, SAT ? 32'h7FFFFFFF : 32'h80000000, 1'b1, 1'b1, 1'b0};
        vecs[1]  = '{32'h00000005, 32'h00000005, 1'b1, 32'h00000000, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{32'h00000003, 32'h00000007, 1'b1, 32'hFFFFFFFC, 1'b0, 1'b1, 1'b1};
        vecs[3]  = '{32'h80000000, 32'h00000001, 1'b1, SAT ? 32'h80000000 : 32'h7FFFFFFF, 1'b1, 1'b1, 1'b1};
        vecs[4]  = '{32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{32'h00000007, 32'h00000003, 1'b1, 32'h00000004, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000 & {32{SAT}}, 1'b1, 1'b0, 1'b1};
        vecs[8]  = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b1};
        vecs[9]  = '{32'h12345678, 32'h0F0F0F0F, 1'b0, 32'h21436587, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b1, 1'b0};

        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        check_idle("reset");
        check("reset result", result, 32'h0);
        check("reset flags", {29'd0, overflow, isNotEqual, isLessThan}, 32'h0);

        for (int i = 0; i < 11; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Backpressure: DONE holds everything while inputs churn.
        issue(32'h00000003, 32'h00000007, 1'b1);
        repeat (NCH) @(posedge clock);
        #1;
        check("bp out_valid", 32'(out_valid), 32'd1);
        held = result;
        check("bp result", held, 32'hFFFFFFFC);
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            in_valid = ~in_valid;
            data_A   = $urandom;
            data_B   = $urandom;
            cin      = 1'($urandom);
            @(posedge clock);
            #1;
            check($sformatf("bp%0d result", k), result, held);
            check($sformatf("bp%0d flags", k), {29'd0, overflow, isNotEqual, isLessThan}, 32'h3);
            check($sformatf("bp%0d in_ready", k), 32'(in_ready), 32'd0);
            check($sformatf("bp%0d out_valid", k), 32'(out_valid), 32'd1);
        end
        @(negedge clock);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        check_idle("bp release");

        // Reset sampled at the end of the second RUN cycle discards the operation.
        issue(32'h7FFFFFFF, 32'h00000001, 1'b0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        check_idle("midreset");
        check("midreset result", result, 32'h0);
        check("midreset flags", {29'd0, overflow, isNotEqual, isLessThan}, 32'h0);
        for (int k = 0; k < NCH + 2; k++) begin
            @(posedge clock);
            #1;
            check($sformatf("midreset quiet%0d", k), 32'(out_valid), 32'd0);
        end
        run_vec('{32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 1'b0, 1'b1, 1'b0}, "after reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
